// File: rtl/char_motion_ctrl.sv
// Bounces the glyph block origin around the active area and cycles its colour on each bounce.
// Latency: outputs and frame_tick register on the edge that samples the last active pixel.
// No backpressure: step_req pulses are latched while paused, run_en is a level.
module char_motion_ctrl #(
  parameter int H_VALID   = 640,
  parameter int V_VALID   = 480,
  parameter int CHAR_W    = 256,
  parameter int CHAR_H    = 64,
  parameter int INIT_X    = 192,
  parameter int INIT_Y    = 208,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        run_en,
  input  logic        step_req,
  output logic [9:0]  char_base_x,
  output logic [9:0]  char_base_y,
  output logic [15:0] fg_color,
  output logic        frame_tick,
  output logic [7:0]  bounce_cnt
);

  localparam logic [10:0] X_MAX_W  = 11'(H_VALID - CHAR_W);
  localparam logic [10:0] Y_MAX_W  = 11'(V_VALID - CHAR_H);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0]  LAST_X   = 10'(H_VALID - 1);
  localparam logic [9:0]  LAST_Y   = 10'(V_VALID - 1);

  localparam logic [15:0] GOLDEN = 16'hFEC0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;

  typedef enum logic {PAUSE, RUN} state_t;

  // One axis after a move: new position, direction (1 = right/down) and whether it hit an edge.
  typedef struct packed {
    logic [9:0] pos;
    logic       fwd;
    logic       hit;
  } axis_t;

  // Moves one axis by STEP, clamping to [0, lim] and reversing on contact.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic fwd, input logic [10:0] lim);
    axis_t      r;
    logic [10:0] nxt;
    nxt   = {1'b0, pos} + STEP_W;
    r.pos = pos;
    r.fwd = fwd;
    r.hit = 1'b0;
    if (fwd) begin
      if (nxt >= lim) begin
        r.pos = lim[9:0];
        r.fwd = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = nxt[9:0];
      end
    end else begin
      if ({1'b0, pos} <= STEP_W) begin
        r.pos = '0;
        r.fwd = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - STEP_W[9:0];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] next_color(input logic [15:0] c);
    logic [15:0] n;
    case (c)
      GOLDEN:  n = RED;
      RED:     n = GREEN;
      GREEN:   n = BLUE;
      default: n = GOLDEN;
    endcase
    return n;
  endfunction

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_cnt_nxt;
  logic       step_pend, step_pend_nxt;
  logic       do_update;
  logic       frame_evt;
  logic       dir_x, dir_y;
  axis_t      ax, ay;
  logic       bounce;

  assign frame_evt = (pix_x == LAST_X) && (pix_y == LAST_Y);
  assign ax        = axis_step(char_base_x, dir_x, X_MAX_W);
  assign ay        = axis_step(char_base_y, dir_y, Y_MAX_W);
  assign bounce    = ax.hit | ay.hit;

  // Mode, update pacing and step latch; mode changes and updates happen only on the frame event.
  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt;
    step_pend_nxt = step_pend;
    do_update     = 1'b0;
    case (state)
      PAUSE: begin
        if (frame_evt) begin
          if (run_en) begin
            state_nxt     = RUN;
            step_pend_nxt = 1'b0;
          end else begin
            // A pulse landing on the event edge belongs to the next frame.
            do_update     = step_pend;
            step_pend_nxt = step_req;
          end
        end else begin
          step_pend_nxt = step_pend | step_req;
        end
      end
      RUN: begin
        step_pend_nxt = 1'b0;
        if (frame_evt) begin
          if (!run_en) begin
            state_nxt   = PAUSE;
            div_cnt_nxt = '0;
          end else if (div_cnt == DIV_LAST) begin
            do_update   = 1'b1;
            div_cnt_nxt = '0;
          end else begin
            div_cnt_nxt = div_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = PAUSE;
    endcase
  end

  // Control state register.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= PAUSE;
      div_cnt   <= '0;
      step_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      step_pend <= step_pend_nxt;
    end
  end

  // Origin, direction, colour and bounce count; a corner hit counts as a single bounce.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      char_base_x <= 10'(INIT_X);
      char_base_y <= 10'(INIT_Y);
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      fg_color    <= GOLDEN;
      bounce_cnt  <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= frame_evt;
      if (do_update) begin
        char_base_x <= ax.pos;
        dir_x       <= ax.fwd;
        char_base_y <= ay.pos;
        dir_y       <= ay.fwd;
        if (bounce) begin
          bounce_cnt <= bounce_cnt + 8'd1;
          fg_color   <= next_color(fg_color);
        end
      end
    end
  end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: two instances (default, and corner start with a frame divider of 3)
// share a compressed-frame stimulus; a reference model queues the expected outputs per frame
// event and a monitor pops them on every frame_tick, also checking outputs hold between ticks.
`timescale 1ns/1ps
module tb_char_motion_ctrl;

  localparam int X_MAX = 384;
  localparam int Y_MAX = 416;
  localparam int STEP  = 2;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] c;
    logic [7:0]  bc;
  } obs_t;

  typedef struct {
    bit run;
    bit pend;
    int div;
    int x;
    int y;
    int dx;
    int dy;
    int cidx;
    int bcnt;
  } mdl_t;

  logic        vga_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x     = '0;
  logic [9:0]  pix_y     = '0;
  logic        run_en    = 1'b0;
  logic        step_req  = 1'b0;
  logic [9:0]  a_x, a_y, b_x, b_y;
  logic [15:0] a_c, b_c;
  logic        a_tick, b_tick;
  logic [7:0]  a_bc, b_bc;

  logic [15:0] palette [4] = '{16'hFEC0, 16'hF800, 16'h07E0, 16'h001F};
  mdl_t        m [2];
  obs_t        q [2][$];
  obs_t        held [2];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic        run_lvl = 1'b0;

  char_motion_ctrl u_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .run_en(run_en), .step_req(step_req),
    .char_base_x(a_x), .char_base_y(a_y), .fg_color(a_c), .frame_tick(a_tick), .bounce_cnt(a_bc)
  );

  char_motion_ctrl #(.INIT_X(380), .INIT_Y(412), .FRAME_DIV(3)) u_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .run_en(run_en), .step_req(step_req),
    .char_base_x(b_x), .char_base_y(b_y), .fg_color(b_c), .frame_tick(b_tick), .bounce_cnt(b_bc)
  );

  always #5 vga_clk = ~vga_clk;

  // ---------------- reference model ----------------
  function automatic mdl_t mdl_init(input int i);
    mdl_t r;
    r.run = 1'b0; r.pend = 1'b0; r.div = 0;
    r.x = (i == 0) ? 192 : 380;
    r.y = (i == 0) ? 208 : 412;
    r.dx = 1; r.dy = 1; r.cidx = 0; r.bcnt = 0;
    return r;
  endfunction

  function automatic mdl_t move(input mdl_t s);
    mdl_t r = s;
    bit   hit = 1'b0;
    r.x = s.x + STEP * s.dx;
    if (r.x >= X_MAX || r.x <= 0) begin
      r.x = (r.x >= X_MAX) ? X_MAX : 0;
      r.dx = -s.dx;
      hit = 1'b1;
    end
    r.y = s.y + STEP * s.dy;
    if (r.y >= Y_MAX || r.y <= 0) begin
      r.y = (r.y >= Y_MAX) ? Y_MAX : 0;
      r.dy = -s.dy;
      hit = 1'b1;
    end
    if (hit) begin
      r.bcnt = (s.bcnt + 1) % 256;
      r.cidx = (s.cidx + 1) % 4;
    end
    return r;
  endfunction

  function automatic mdl_t mdl_edge(input mdl_t s, input int fd, input bit evt, input bit run, input bit step);
    mdl_t r = s;
    if (!evt) begin
      if (!s.run) r.pend = s.pend | step;
      return r;
    end
    if (!s.run) begin
      if (run) begin
        r.run = 1'b1; r.pend = 1'b0; r.div = 0;
      end else begin
        if (s.pend) r = move(s);
        r.pend = step;
      end
    end else if (!run) begin
      r.run = 1'b0; r.div = 0;
    end else begin
      r.div = s.div + 1;
      if (r.div == fd) begin
        r = move(r);
        r.div = 0;
      end
    end
    return r;
  endfunction

  function automatic obs_t mdl_obs(input mdl_t s);
    obs_t o;
    o.x = 10'(s.x); o.y = 10'(s.y); o.c = palette[s.cidx]; o.bc = 8'(s.bcnt);
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic mon(input int i, input logic tick, input obs_t now);
    string nm;
    obs_t  e;
    nm = (i == 0) ? "a" : "b";
    if (tick !== 1'b0) begin
      chk({nm, "_tick_pending"}, q[i].size(), 1);
      if (q[i].size() > 0) begin
        e = q[i].pop_front();
        chk({nm, "_x"}, now.x, e.x);
        chk({nm, "_y"}, now.y, e.y);
        chk({nm, "_color"}, now.c, e.c);
        chk({nm, "_bounce_cnt"}, now.bc, e.bc);
        held[i] = e;
      end
    end else begin
      chk({nm, "_hold"}, now, held[i]);
    end
  endtask

  // Monitor: compares on every frame_tick, checks stability otherwise.
  always @(negedge vga_clk) begin
    if (sys_rst_n !== 1'b1) begin
      held[0] = mdl_obs(mdl_init(0));
      held[1] = mdl_obs(mdl_init(1));
    end else begin
      mon(0, a_tick, obs_t'({a_x, a_y, a_c, a_bc}));
      mon(1, b_tick, obs_t'({b_x, b_y, b_c, b_bc}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic run, input logic step);
    bit evt;
    @(negedge vga_clk);
    pix_x = px; pix_y = py; run_en = run; step_req = step;
    evt = (px == 10'd639) && (py == 10'd479);
    for (int i = 0; i < 2; i++) begin
      m[i] = mdl_edge(m[i], (i == 0) ? 1 : 3, evt, run, step);
      if (evt) q[i].push_back(mdl_obs(m[i]));
    end
  endtask

  task automatic drive_rand(input logic run, input logic step);
    logic [9:0] px, py;
    px = ($urandom_range(0, 3) == 0) ? 10'd639 : 10'($urandom_range(0, 799));
    py = ($urandom_range(0, 3) == 0) ? 10'd479 : 10'($urandom_range(0, 524));
    if (px == 10'd639 && py == 10'd479) py = 10'd478;
    drive(px, py, run, step);
  endtask

  task automatic frame(input int len, input logic run);
    for (int c = 0; c < len - 1; c++) drive_rand(run, 1'b0);
    drive(10'd639, 10'd479, run, 1'b0);
  endtask

  task automatic sample();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic exp_a(input string nm, input int ex, input int ey, input int ec, input int ebc);
    chk({"a_", nm, "_x"}, a_x, ex);
    chk({"a_", nm, "_y"}, a_y, ey);
    chk({"a_", nm, "_color"}, a_c, ec);
    chk({"a_", nm, "_bounce_cnt"}, a_bc, ebc);
  endtask

  task automatic exp_b(input string nm, input int ex, input int ey, input int ec, input int ebc);
    chk({"b_", nm, "_x"}, b_x, ex);
    chk({"b_", nm, "_y"}, b_y, ey);
    chk({"b_", nm, "_color"}, b_c, ec);
    chk({"b_", nm, "_bounce_cnt"}, b_bc, ebc);
  endtask

  // Asserts reset between clock edges and checks outputs have already returned home.
  task automatic do_reset();
    @(negedge vga_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    exp_a("rst", 192, 208, 16'hFEC0, 0);
    exp_b("rst", 380, 412, 16'hFEC0, 0);
    chk("a_rst_tick", a_tick, 0);
    pix_x = '0; pix_y = '0; run_en = 1'b0; step_req = 1'b0; run_lvl = 1'b0;
    repeat (2) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    m[0] = mdl_init(0);
    m[1] = mdl_init(1);
  endtask

  initial begin
    int   len;
    logic stp;
    m[0] = mdl_init(0);
    m[1] = mdl_init(1);
    do_reset();

    // Paused: nothing moves, frame_tick still pulses.
    repeat (3) frame(4, 1'b0);
    sample(); exp_a("idle", 192, 208, 16'hFEC0, 0);

    // Free run: first event only enters RUN.
    frame(4, 1'b1);
    frame(4, 1'b1); sample(); exp_a("run1", 194, 210, 16'hFEC0, 0);
    repeat (5) frame(4, 1'b1); sample(); exp_b("corner", 384, 416, 16'hF800, 1);
    repeat (3) frame(4, 1'b1); sample(); exp_b("corner_back", 382, 414, 16'hF800, 1);
    repeat (87) frame(4, 1'b1); sample(); exp_a("x_bounce", 384, 400, 16'hF800, 1);
    frame(4, 1'b1); sample(); exp_a("x_left", 382, 402, 16'hF800, 1);
    repeat (7) frame(4, 1'b1); sample(); exp_a("y_bounce", 368, 416, 16'h07E0, 2);

    // Run to x=300, then reset mid-frame.
    do_reset();
    frame(4, 1'b1);
    repeat (54) frame(4, 1'b1); sample(); exp_a("pre_rst", 300, 316, 16'hFEC0, 0);
    drive_rand(1'b1, 1'b0);
    drive_rand(1'b1, 1'b0);
    do_reset();

    // Several step pulses in one paused frame collapse to one update.
    drive_rand(1'b0, 1'b0); drive_rand(1'b0, 1'b1); drive_rand(1'b0, 1'b1);
    drive_rand(1'b0, 1'b0); drive_rand(1'b0, 1'b1);
    drive(10'd639, 10'd479, 1'b0, 1'b0);
    sample(); exp_a("step", 194, 210, 16'hFEC0, 0); exp_b("step", 382, 414, 16'hFEC0, 0);
    frame(4, 1'b0); sample(); exp_a("step_once", 194, 210, 16'hFEC0, 0);
    // Step on the event edge is serviced one frame later.
    drive_rand(1'b0, 1'b0);
    drive(10'd639, 10'd479, 1'b0, 1'b1);
    sample(); exp_a("step_coinc", 194, 210, 16'hFEC0, 0);
    frame(4, 1'b0); sample(); exp_a("step_late", 196, 212, 16'hFEC0, 0);
    exp_b("step_late", 384, 416, 16'hF800, 1);

    // run_en dropped mid-frame: no update, divider restarts from zero.
    frame(4, 1'b1);
    frame(4, 1'b1);
    drive_rand(1'b1, 1'b0); drive_rand(1'b0, 1'b0); drive_rand(1'b0, 1'b0);
    drive(10'd639, 10'd479, 1'b0, 1'b0);
    sample(); exp_b("drop", 384, 416, 16'hF800, 1);
    frame(4, 1'b1);
    frame(4, 1'b1); frame(4, 1'b1); sample(); exp_b("div_clr", 384, 416, 16'hF800, 1);
    frame(4, 1'b1); sample(); exp_b("div_upd", 382, 414, 16'hF800, 1);

    // Randomised frames, run_en toggling at arbitrary cycles, random step pulses.
    for (int f = 0; f < 300; f++) begin
      len = $urandom_range(2, 8);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) run_lvl = ~run_lvl;
        stp = ($urandom_range(0, 3) == 0);
        if (c == len - 1) drive(10'd639, 10'd479, run_lvl, stp);
        else drive_rand(run_lvl, stp);
      end
    end
    repeat (4) drive_rand(1'b0, 1'b0);
    @(negedge vga_clk);
    chk("a_ticks_drained", q[0].size(), 0);
    chk("b_ticks_drained", q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
